// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive back end; walks a loaded 11-bit frame bit by bit.
// Define UART_RX_PARITY_EN to enable the even-parity check on rx[9].
module uart_rx_frame #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        ret,
  input  logic        wr,
  input  logic [10:0] rx,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        frame_err,
  output logic        parity_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [10:0] shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        wr_q;
  logic        rise;
  logic        last;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        pflag_q, pflag_d;
  logic        perr_q, perr_d;
`endif

  assign rise = wr & ~wr_q;

  // Next-state and pulse logic; one frame bit is consumed per BIT_CYCLES.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pflag_d = pflag_q;
    perr_d  = 1'b0;
`endif
    last = (cyc_q == LAST_CYC);
    if (state_q != IDLE) begin
      cyc_d = last ? 8'd0 : cyc_q + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          shift_d = rx;
          bit_d   = 3'd0;
          cyc_d   = 8'd0;
          acc_d   = 8'd0;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
          pflag_d = 1'b0;
`endif
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          shift_d = {1'b0, shift_q[10:1]};
          if (shift_q[0]) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (last) begin
          acc_d   = {shift_q[0], acc_q[7:1]};
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          shift_d = {1'b0, shift_q[10:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (last) begin
`ifdef UART_RX_PARITY_EN
          pflag_d = par_q ^ shift_q[0];
`endif
          shift_d = {1'b0, shift_q[10:1]};
          state_d = STOP;
        end
      end
      STOP: begin
        if (last) begin
          state_d = IDLE;
          if (!shift_q[0]) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (pflag_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            dout_d  = acc_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (ret) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      wr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pflag_q <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      wr_q    <= wr;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pflag_q <= pflag_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out  = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of uart_rx_frame.
// Parity expectations follow UART_RX_PARITY_EN.
module tb_uart_rx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ret, wr;
  logic [10:0] rx;
  logic [7:0]  data_out;
  logic        valid, frame_err, parity_err;

  logic        ret4, wr4;
  logic [10:0] rx4;
  logic [7:0]  data_out4;
  logic        valid4, frame_err4, parity_err4;

`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  uart_rx_frame #(.BIT_CYCLES(1)) dut (
    .clk        (clk),
    .ret        (ret),
    .wr         (wr),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  uart_rx_frame #(.BIT_CYCLES(4)) dut4 (
    .clk        (clk),
    .ret        (ret4),
    .wr         (wr4),
    .rx         (rx4),
    .data_out   (data_out4),
    .valid      (valid4),
    .frame_err  (frame_err4),
    .parity_err (parity_err4)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pulses();
    return {valid, frame_err, parity_err};
  endfunction

  // Load frame f, expect pulse vector p at E0+lat only, then data d.
  task automatic run_frame(input string tag, input logic [10:0] f,
                           input int lat, input logic [2:0] p,
                           input logic [7:0] d);
    rx = f;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      check($sformatf("%s pulse@E0+%0d", tag, k), 32'(pulses()),
            (k == lat) ? 32'(p) : 32'd0);
    end
    check({tag, " data"}, 32'(data_out), 32'(d));
  endtask

  initial begin
    ret  = 1'b1;
    wr   = 1'b0;
    rx   = '0;
    ret4 = 1'b1;
    wr4  = 1'b0;
    rx4  = '0;

    for (int i = 0; i < 3; i++) begin
      wr  = ~wr;
      wr4 = ~wr4;
      tick();
      check("rst pulses", 32'(pulses()), 32'd0);
      check("rst data", 32'(data_out), 32'd0);
    end
    ret  = 1'b0;
    ret4 = 1'b0;
    wr   = 1'b0;
    wr4  = 1'b0;
    tick();

    rx4 = 11'h54A;
    wr4 = 1'b1;
    tick();
    wr4 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      check($sformatf("bc4 pulse@E0+%0d", k),
            32'({valid4, frame_err4, parity_err4}),
            (k == 44) ? 32'h4 : 32'h0);
    end
    check("bc4 data", 32'(data_out4), 32'hA5);

    run_frame("good A5", 11'h54A, 11, 3'b100, 8'hA5);
    run_frame("good 3C", 11'h478, 11, 3'b100, 8'h3C);
    run_frame("parity", 11'h74A, 11,
              PEN ? 3'b001 : 3'b100, PEN ? 8'h3C : 8'hA5);
    run_frame("odd data", 11'h602, 11, 3'b100, 8'h01);
    run_frame("start err", 11'h54B, 1, 3'b010, 8'h01);
    run_frame("stop err", 11'h14A, 11, 3'b010, 8'h01);

    rx = 11'h54A;
    wr = 1'b1;
    tick();
    rx = 11'h002;
    for (int k = 1; k <= 23; k++) begin
      wr = (((k >> 1) & 1) == 0);
      tick();
      check($sformatf("busy pulse@E0+%0d", k), 32'(pulses()),
            (k == 11) ? 32'h4 : (k == 23) ? 32'h2 : 32'h0);
      if (k == 11) check("busy data", 32'(data_out), 32'hA5);
    end
    wr = 1'b0;
    tick();
    check("busy tail", 32'(pulses()), 32'd0);
    check("busy data kept", 32'(data_out), 32'hA5);

    rx = 11'h54A;
    wr = 1'b1;
    tick();
    wr = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("midrst data", 32'(data_out), 32'd0);
    for (int k = 6; k <= 13; k++) begin
      tick();
      check($sformatf("midrst pulse@E0+%0d", k), 32'(pulses()), 32'd0);
    end
    run_frame("after rst", 11'h54A, 11, 3'b100, 8'hA5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
